aes_key_sched_stream: RTL

//  Multi-mode AES key-schedule engine (AES-128/192/256) that streams all Nr+1 round keys from one master key.

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_sbox_word.sv | 13 +
 rtl/aes_key_sched_stream.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: mode and FSM enums, key-length lookups, GF(2^8) doubling, S-box table.
package aes_pkg;

    typedef enum logic [1:0] {
        ModeAes128  = 2'd0,
        ModeAes192  = 2'd1,
        ModeAes256  = 2'd2,
        ModeIllegal = 2'd3
    } aes_mode_e;

    typedef enum logic {
        StIdle,
        StRun
    } sched_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Row 0 in the MSBs: entry b lives at bits [8*(255-b) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [3:0] nk_of(input aes_mode_e mode);
        case (mode)
            ModeAes128: return 4'd4;
            ModeAes192: return 4'd6;
            ModeAes256: return 4'd8;
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input aes_mode_e mode);
        case (mode)
            ModeAes128: return 4'd10;
            ModeAes192: return 4'd12;
            ModeAes256: return 4'd14;
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel combinational S-box lookups on a 32-bit word.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign sub[8*g +: 8] = sbox(word[8*g +: 8]);
    end

endmodule

// File: rtl/aes_key_sched_stream.sv
// Streaming AES-128/192/256 key schedule: one schedule word per cycle, 128-bit round keys
// delivered over valid/ready.
module aes_key_sched_stream
    import aes_pkg::*;
#(
    parameter int unsigned MAX_KEY_BITS = 256,
    parameter int unsigned IDX_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [255:0]     key_i,
    output logic [127:0]     rk_o,
    output logic [IDX_W-1:0] rk_idx_o,
    output logic             rk_last_o,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    sched_state_e state, next_state;

    // win[0] is w[i-1], win[nk-1] is w[i-nk]
    logic [31:0]      win [8];
    logic [31:0]      acc [3];
    logic [1:0]       acc_cnt;
    logic [5:0]       word_cnt;
    logic [5:0]       total_words;
    logic [2:0]       kmod;
    logic [3:0]       nk;
    logic [IDX_W-1:0] nr;
    logic [IDX_W-1:0] key_num;
    logic [7:0]       rcon;

    aes_mode_e    start_mode;
    logic [3:0]   start_nk;
    logic         start_legal;
    logic         start_ok;
    logic         start_bad;
    logic [255:0] key_sh;
    logic         xfer;
    logic         last_xfer;
    logic         gen_en;
    logic [31:0]  prev_word;
    logic [31:0]  old_word;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  new_word;

    assign start_mode  = aes_mode_e'(mode_i);
    assign start_nk    = nk_of(start_mode);
    assign start_legal = (start_mode != ModeIllegal) && ((32'(start_nk) * 32'd32) <= MAX_KEY_BITS);
    // Right-align the Nk key words so win[j] = key word nk-1-j falls out of a constant slice.
    assign key_sh      = key_i >> (32 * (8 - int'(start_nk)));

    assign xfer      = rk_valid_o && rk_ready_i;
    assign last_xfer = xfer && rk_last_o;
    assign busy_o    = (state == StRun);
    assign gen_en    = (state == StRun) && (word_cnt < total_words) &&
                       ((acc_cnt != 2'd3) || !rk_valid_o || rk_ready_i);

    always_ff @(posedge clk) begin
        if (rst) state <= StIdle;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        unique case (state)
            StIdle: begin
                if (start_i) begin
                    if (start_legal) begin
                        start_ok   = 1'b1;
                        next_state = StRun;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            StRun: begin
                if (last_xfer) next_state = StIdle;
            end
        endcase
    end

    assign prev_word = win[0];
    assign old_word  = win[3'(nk - 4'd1)];
    assign sub_in    = (kmod == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sbox_word u_sbox_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        new_word = old_word ^ prev_word;
        if (word_cnt < 6'(nk)) begin
            new_word = win[3'(nk - 4'd1 - word_cnt[3:0])];
        end else if (kmod == 3'd0) begin
            new_word = old_word ^ sub_out ^ {rcon, 24'h0};
        end else if ((nk == 4'd8) && (kmod == 3'd4)) begin
            new_word = old_word ^ sub_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 8; j++) win[j] <= '0;
            for (int j = 0; j < 3; j++) acc[j] <= '0;
            acc_cnt     <= '0;
            word_cnt    <= '0;
            total_words <= '0;
            kmod        <= '0;
            nk          <= '0;
            nr          <= '0;
            key_num     <= '0;
            rcon        <= '0;
            rk_o        <= '0;
            rk_idx_o    <= '0;
            rk_last_o   <= 1'b0;
            rk_valid_o  <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= last_xfer;
            err_o  <= start_bad;
            if (start_ok) begin
                for (int j = 0; j < 8; j++) win[j] <= key_sh[32*j +: 32];
                acc_cnt     <= '0;
                word_cnt    <= '0;
                kmod        <= '0;
                nk          <= start_nk;
                nr          <= IDX_W'(nr_of(start_mode));
                total_words <= {nr_of(start_mode) + 4'd1, 2'b00};
                key_num     <= '0;
                rcon        <= RCON_INIT;
            end else begin
                if (gen_en) begin
                    word_cnt <= word_cnt + 6'd1;
                    kmod     <= (kmod == 3'(nk - 4'd1)) ? 3'd0 : kmod + 3'd1;
                    if (word_cnt >= 6'(nk)) begin
                        win[0] <= new_word;
                        for (int j = 7; j > 0; j--) win[j] <= win[j-1];
                        if (kmod == 3'd0) rcon <= xtime(rcon);
                    end
                    if (acc_cnt == 2'd3) begin
                        rk_o       <= {acc[0], acc[1], acc[2], new_word};
                        rk_valid_o <= 1'b1;
                        rk_idx_o   <= key_num;
                        rk_last_o  <= (key_num == nr);
                        if (key_num != nr) key_num <= key_num + 1'b1;
                        acc_cnt    <= '0;
                    end else begin
                        acc[acc_cnt] <= new_word;
                        acc_cnt      <= acc_cnt + 2'd1;
                    end
                end
                if (xfer && !(gen_en && (acc_cnt == 2'd3))) rk_valid_o <= 1'b0;
                if (last_xfer) begin
                    rk_valid_o <= 1'b0;
                    rk_idx_o   <= '0;
                    rk_last_o  <= 1'b0;
                end
            end
        end
    end

endmodule
